gray_gauss3_stage: RTL and testbench
====================================

// Module: gray_gauss3_stage
// PURPOSE
//  3x3 Gaussian smoothing stage between grayscale_producer and filter_stage.
//  Consumes the streamed gray pixel in raster order, keyed by hcount/vcount from vga_sync.
//  Two on-chip line buffers give the vertical window.
//  Delays hsync/vsync/blank_n/visible by the same fixed latency, so VGA timing stays aligned.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line; line-buffer depth
//  DATA_W     8    pixel width
//  SYNC_IDLE  1    reset value driven on hsync_out/vsync_out (inactive level)
// PORTS
//  clk          in   1       pixel clock (pix_clk)
//  reset        in   1       async, active-high
//  hcount       in   10      current column from vga_sync
//  vcount       in   10      current row from vga_sync
//  visible      in   1       active-area flag
//  hsync_in     in   1       from vga_sync
//  vsync_in     in   1       from vga_sync
//  blank_n_in   in   1       from vga_sync
//  pixel_in     in   DATA_W  gray pixel from producer
//  valid_in     in   1       pixel_in qualifier
//  enable       in   1       1=filter, 0=bypass; sampled at frame start only
//  pixel_out    out  DATA_W  filtered pixel to filter_stage
//  valid_out    out  1       delayed (visible & valid_in)
//  visible_out  out  1       delayed visible
//  hsync_out    out  1       delayed hsync_in
//  vsync_out    out  1       delayed vsync_in
//  blank_n_out  out  1       delayed blank_n_in
// BEHAVIOUR
//  - Reset: pixel_out=0, valid_out=0, visible_out=0, blank_n_out=0, hsync_out=vsync_out=SYNC_IDLE, en_q=0.
//  - Latency: fixed 4 clk for every output, with or without filtering. All sideband signals go through a 4-deep shift register.
//  - Pixel pipeline:
//    - S1: register inputs; p = valid_in ? pixel_in : 0; issue line-buffer read at hcount.
//    - S2: rA = lineA[x] (row y-1), rB = lineB[x] (row y-2).
//      If visible: write lineA[x]<=p, lineB[x]<=rA (read-before-write, same address).
//    - S3: vertical sum v = rB + 2*rA + p (10b).
//    - S4: horizontal sum h = v[x-2] + 2*v[x-1] + v[x] (12b); out = (h+8)>>4 (round, max 255, no overflow).
//  - Clamp (edge replicate):
//    - y==0: rA=rB=p. y==1: rB=rA.
//    - x==0: v[x-1]=v[x-2]=v[x]. x==1: v[x-2]=v[x-1].
//  - Output at (x,y) is centred on source (x-1,y-1): deliberate one-row/one-column shift; last source row/column never centred.
//  - Outside visible: line buffers not written, horizontal history not advanced, pixel_out=0.
//  - enable: en_q <= enable when hcount==0 && vcount==0 (S1). No mid-frame change.
//    en_q=0: pixel_out = p delayed 4 clk; line buffers still update.
//  - Reset mid-frame: pipeline clears, line RAM not reset. Pixel values undefined until next vcount==0; sync outputs correct after 4 clk.
//  - hcount >= H_ACTIVE while visible=1: no write, output 0 (defensive).
// CONFIGURATION
//  GAUSS3_SHARPEN_EN defined: adds input sharpen (1b), sampled with enable at frame start.
//    When en_q && sharpen_q: out = sat(2*c - blur, 0..255); c = source centre pixel, pipelined to align.
//    Same 4-clk latency.
//  Not defined: port absent, blur/bypass only.
// TESTING
//  - Reset then release: hsync/vsync_out=1, others 0; sync edges appear exactly 4 clk after input edges.
//  - Flat field 100, enable=1: every valid_out pixel = 100, including row 0 and column 0 (clamp check).
//  - Single 255 dot at (10,10) on 0 background: 3x3 outputs centred (11,11) = 16,32,16 / 32,64,32 / 16,32,16.
//  - enable toggled 0->1 mid-frame: bypass (pixel_out=pixel_in, 4-clk delay) until next frame start, then filtered.
//  - valid_in=0 while visible: treated as 0. Vertical step 0->200 at row 50 gives column values 0,50,150,200 at output rows 50..53.
//  - GAUSS3_SHARPEN_EN, same dot: centre 2*255-64 -> 255 (sat); neighbours 2*0-32 -> 0 (sat).

Source files
------------

// File: rtl/gray_gauss3_stage.sv
// 3x3 Gaussian smoothing stage with two line buffers and 4-clk aligned sideband.
// Optional GAUSS3_SHARPEN_EN adds a 'sharpen' input (unsharp mask: 2*centre - blur).
module gray_gauss3_stage #(
   parameter int   H_ACTIVE  = 640,
   parameter int   DATA_W    = 8,
   parameter logic SYNC_IDLE = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [9:0]        hcount,
   input  logic [9:0]        vcount,
   input  logic              visible,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              blank_n_in,
   input  logic [DATA_W-1:0] pixel_in,
   input  logic              valid_in,
`ifdef GAUSS3_SHARPEN_EN
   input  logic              sharpen,
`endif
   input  logic              enable,
   output logic [DATA_W-1:0] pixel_out,
   output logic              valid_out,
   output logic              visible_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              blank_n_out
);

   localparam int AW = $clog2(H_ACTIVE);
   localparam int VW = DATA_W + 2;
   localparam int HW = DATA_W + 4;

   logic [DATA_W-1:0] line_a [H_ACTIVE];
   logic [DATA_W-1:0] line_b [H_ACTIVE];
   logic [DATA_W-1:0] ra_q, rb_q;

   logic              in_act;
   logic [DATA_W-1:0] p1, p2, f3;
   logic [9:0]        x1, y1, x2;
   logic              act1, act2, en_q, en2;
   logic [VW-1:0]     v2, hv1, hv2, v_next, vm1, vm2;
   logic [DATA_W-1:0] ra_c, rb_c, blur, f_next;
   logic [HW-1:0]     h_sum, h_rnd;
   logic [3:0]        vis_sr, vld_sr, hs_sr, vs_sr, bl_sr;

   assign in_act = visible && (hcount < 10'(H_ACTIVE));

   // Line RAM is never reset; read and write share one port cycle (read-before-write).
   always_ff @(posedge clk) begin
      if (in_act) begin
         ra_q <= line_a[hcount[AW-1:0]];
         rb_q <= line_b[hcount[AW-1:0]];
      end
      if (act1) begin
         line_a[x1[AW-1:0]] <= p1;
         line_b[x1[AW-1:0]] <= ra_q;
      end
   end

   always_comb begin
      ra_c   = (y1 == 10'd0) ? p1 : ra_q;
      rb_c   = (y1 == 10'd0) ? p1 : ((y1 == 10'd1) ? ra_q : rb_q);
      v_next = VW'(rb_c) + VW'({ra_c, 1'b0}) + VW'(p1);
      vm1    = (x2 == 10'd0) ? v2 : hv1;
      vm2    = (x2 == 10'd0) ? v2 : ((x2 == 10'd1) ? hv1 : hv2);
      h_sum  = HW'(vm2) + HW'({vm1, 1'b0}) + HW'(v2);
      h_rnd  = h_sum + HW'(8);
      blur   = h_rnd[HW-1:4];
   end

`ifdef GAUSS3_SHARPEN_EN
   logic              sharpen_q, shp2;
   logic [DATA_W-1:0] c2, hc1, cc, sharp;
   logic [DATA_W:0]   two, diff;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sharpen_q <= 1'b0;
         shp2      <= 1'b0;
         c2        <= '0;
         hc1       <= '0;
      end else begin
         if (hcount == 10'd0 && vcount == 10'd0) sharpen_q <= sharpen;
         shp2 <= sharpen_q;
         c2   <= ra_c;
         if (act2) hc1 <= c2;
      end
   end

   always_comb begin
      cc    = (x2 == 10'd0) ? c2 : hc1;
      two   = {cc, 1'b0};
      diff  = two - {1'b0, blur};
      sharp = '0;
      if (two > {1'b0, blur}) sharp = diff[DATA_W] ? '1 : diff[DATA_W-1:0];
   end
`endif

   always_comb begin
      f_next = '0;
      if (act2) f_next = en2 ? blur : p2;
`ifdef GAUSS3_SHARPEN_EN
      if (act2 && en2 && shp2) f_next = sharp;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p1 <= '0; x1 <= '0; y1 <= '0; act1 <= 1'b0; en_q <= 1'b0;
         v2 <= '0; p2 <= '0; x2 <= '0; act2 <= 1'b0; en2 <= 1'b0;
         hv1 <= '0; hv2 <= '0; f3 <= '0; pixel_out <= '0;
         vis_sr <= '0; vld_sr <= '0; bl_sr <= '0;
         hs_sr <= {4{SYNC_IDLE}};
         vs_sr <= {4{SYNC_IDLE}};
      end else begin
         p1   <= valid_in ? pixel_in : '0;
         x1   <= hcount;
         y1   <= vcount;
         act1 <= in_act;
         if (hcount == 10'd0 && vcount == 10'd0) en_q <= enable;
         v2   <= v_next;
         p2   <= p1;
         x2   <= x1;
         act2 <= act1;
         en2  <= en_q;
         // Horizontal history only advances on active pixels, so blanking cannot smear it.
         if (act2) begin
            hv1 <= v2;
            hv2 <= hv1;
         end
         f3        <= f_next;
         pixel_out <= f3;
         vis_sr <= {vis_sr[2:0], visible};
         vld_sr <= {vld_sr[2:0], visible & valid_in};
         hs_sr  <= {hs_sr[2:0], hsync_in};
         vs_sr  <= {vs_sr[2:0], vsync_in};
         bl_sr  <= {bl_sr[2:0], blank_n_in};
      end
   end

   assign valid_out   = vld_sr[3];
   assign visible_out = vis_sr[3];
   assign hsync_out   = hs_sr[3];
   assign vsync_out   = vs_sr[3];
   assign blank_n_out = bl_sr[3];

endmodule

// File: tb/tb_gray_gauss3_stage.sv
// Self-checking bench for gray_gauss3_stage: reduced raster, image-level Gaussian reference model.
module tb_gray_gauss3_stage;

   localparam int H_ACT = 16;
   localparam int H_TOT = 20;
   localparam int V_ACT = 56;
   localparam int V_TOT = 58;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [9:0] hcount = '0, vcount = '0;
   logic       visible = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1, blank_n_in = 1'b0;
   logic [7:0] pixel_in = '0;
   logic       valid_in = 1'b0, enable = 1'b0;
   logic [7:0] pixel_out;
   logic       valid_out, visible_out, hsync_out, vsync_out, blank_n_out;

   gray_gauss3_stage #(.H_ACTIVE(H_ACT), .DATA_W(8), .SYNC_IDLE(1'b1)) dut (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .visible(visible),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_n_in(blank_n_in),
      .pixel_in(pixel_in), .valid_in(valid_in), .enable(enable),
      .pixel_out(pixel_out), .valid_out(valid_out), .visible_out(visible_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_n_out(blank_n_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pix;
      bit vld, vis, hs, vs, bl, pchk;
      int x, y, m;
   } exp_t;

   exp_t q[$];
   int   img [V_ACT][H_ACT];
   int   hc = 0, vc = 0, mode = 0;
   bit   en_frame = 1'b0, pix_undef = 1'b1;
   int   n_cmp = 0, n_bad = 0;
   int   dot_got [3][3];
   int   step_got [4];

   task automatic chk(input string tag, input int got, input int want);
      n_cmp++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d (x=%0d y=%0d)", tag, got, want, hc, vc);
      end
   endtask

   function automatic exp_t rst_entry();
      exp_t e;
      e.pix = 0; e.vld = 0; e.vis = 0; e.hs = 1; e.vs = 1; e.bl = 0; e.pchk = 1;
      e.x = -1; e.y = -1; e.m = -1;
      return e;
   endfunction

   function automatic int clamp0(input int a);
      return (a < 0) ? 0 : a;
   endfunction

   // Output (x,y) is the 1-2-1 x 1-2-1 kernel over source rows y-2..y, cols x-2..x, edges replicated.
   function automatic int gauss(input int x, input int y);
      int s, wr, wc;
      s = 0;
      for (int j = 0; j < 3; j++)
         for (int i = 0; i < 3; i++) begin
            wr = (j == 1) ? 2 : 1;
            wc = (i == 1) ? 2 : 1;
            s += wr * wc * img[clamp0(y - 2 + j)][clamp0(x - 2 + i)];
         end
      return (s + 8) / 16;
   endfunction

   task automatic drive();
      bit   vis, vld, hs, vs;
      int   pix, p;
      exp_t e;
      vis = (hc < H_ACT) && (vc < V_ACT);
      hs  = !(hc == 17 || hc == 18);
      vs  = (vc != 57);
      if (hc == 0 && vc == 0 && !reset) begin
         en_frame  = enable;
         pix_undef = 1'b0;
      end
      case (mode)
         0: begin pix = 100; vld = 1'b1; end
         1: begin pix = (hc == 10 && vc == 10) ? 255 : 0; vld = 1'b1; end
         3: begin pix = 200; vld = (vc > 50); end
         default: begin pix = $urandom_range(0, 255); vld = ($urandom_range(0, 7) != 0); end
      endcase
      if (!vis) begin
         pix = $urandom_range(0, 255);
         vld = $urandom_range(0, 1) != 0;
      end
      p = vld ? pix : 0;
      if (vis) img[vc][hc] = p;
      hcount = 10'(hc); vcount = 10'(vc); visible = vis;
      hsync_in = hs; vsync_in = vs; blank_n_in = vis;
      pixel_in = 8'(pix); valid_in = vld;
      if (reset) e = rst_entry();
      else begin
         e.pix = vis ? (en_frame ? gauss(hc, vc) : p) : 0;
         e.vld = vis && vld; e.vis = vis; e.hs = hs; e.vs = vs; e.bl = vis;
         e.pchk = !pix_undef; e.x = hc; e.y = vc; e.m = mode;
      end
      q.push_back(e);
      hc++;
      if (hc == H_TOT) begin
         hc = 0;
         vc = (vc == V_TOT - 1) ? 0 : vc + 1;
      end
   endtask

   task automatic cycle(input bit rst_val);
      exp_t e;
      @(posedge clk);
      #1;
      if (rst_val && !reset) begin
         reset = 1'b1;
         #1;
         q.delete();
         repeat (4) q.push_back(rst_entry());
         pix_undef = 1'b1;
      end else if (!rst_val && reset) begin
         reset = 1'b0;
      end
      e = q.pop_front();
      chk("valid_out", int'(valid_out), int'(e.vld));
      chk("visible_out", int'(visible_out), int'(e.vis));
      chk("hsync_out", int'(hsync_out), int'(e.hs));
      chk("vsync_out", int'(vsync_out), int'(e.vs));
      chk("blank_n_out", int'(blank_n_out), int'(e.bl));
      if (e.pchk) chk("pixel_out", int'(pixel_out), e.pix);
      if (e.pchk && e.m == 1 && e.x >= 10 && e.x <= 12 && e.y >= 10 && e.y <= 12)
         dot_got[e.y - 10][e.x - 10] = int'(pixel_out);
      if (e.pchk && e.m == 3 && e.x == 5 && e.y >= 50 && e.y <= 53)
         step_got[e.y - 50] = int'(pixel_out);
      drive();
   endtask

   task automatic run_frame(input int m, input bit en0, input int toggle_row, input int rst_row);
      bit r;
      mode   = m;
      enable = en0;
      for (int n = 0; n < H_TOT * V_TOT; n++) begin
         if (toggle_row >= 0 && vc == toggle_row) enable = 1'b1;
         r = (rst_row >= 0) && (vc == rst_row) && (hc >= 2) && (hc < 5);
         cycle(r);
      end
   endtask

   initial begin : main
      int dot_exp [3][3];
      int step_exp [4];
      dot_exp  = '{'{16, 32, 16}, '{32, 64, 32}, '{16, 32, 16}};
      step_exp = '{0, 50, 150, 200};
      for (int j = 0; j < 3; j++)
         for (int i = 0; i < 3; i++) dot_got[j][i] = -1;
      for (int k = 0; k < 4; k++) step_got[k] = -1;

      #2 reset = 1'b1;
      #1;
      chk("reset_pixel_out", int'(pixel_out), 0);
      chk("reset_valid_out", int'(valid_out), 0);
      chk("reset_visible_out", int'(visible_out), 0);
      chk("reset_blank_n_out", int'(blank_n_out), 0);
      chk("reset_hsync_out", int'(hsync_out), 1);
      chk("reset_vsync_out", int'(vsync_out), 1);
      repeat (4) q.push_back(rst_entry());
      repeat (3) cycle(1'b1);
      hc = 0;
      vc = 0;

      run_frame(0, 1'b1, -1, -1);   // flat field 100
      run_frame(1, 1'b1, -1, -1);   // single dot
      run_frame(2, 1'b1, -1, -1);   // random, filtered
      run_frame(3, 1'b1, -1, -1);   // vertical step via valid_in=0
      run_frame(2, 1'b0, 20, -1);   // enable raised mid-frame: stays bypass
      run_frame(2, 1'b1, -1, -1);   // now filtered
      run_frame(2, 1'b1, -1, 30);   // reset mid-frame
      run_frame(2, 1'b1, -1, -1);   // recovery frame
      repeat (4) cycle(1'b0);

      for (int j = 0; j < 3; j++)
         for (int i = 0; i < 3; i++) chk($sformatf("dot_%0d_%0d", 10 + i, 10 + j), dot_got[j][i], dot_exp[j][i]);
      for (int k = 0; k < 4; k++) chk($sformatf("step_row_%0d", 50 + k), step_got[k], step_exp[k]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
